// File: rtl/noc_traffic_gen_if.sv
// noc_traffic_gen_if: flit stream with a valid/ready handshake.
// master drives flit_out/flit_valid, slave drives flit_ready.
interface noc_traffic_gen_if #(
    parameter int FLIT_W = 64
);
    logic [FLIT_W-1:0] flit_out;
    logic              flit_valid;
    logic              flit_ready;

    modport master (
        output flit_out,
        output flit_valid,
        input  flit_ready
    );

    modport slave (
        input  flit_out,
        input  flit_valid,
        output flit_ready
    );
endinterface

// File: rtl/noc_traffic_gen.sv
// noc_traffic_gen: synthetic wormhole packet source for a NoC injection port.
// Ports: clk, reset (sync, active-high), enable, pkt_len, dest_mode,
//   fixed_dest, inj_gap, tx (flit_out/flit_valid/flit_ready master),
//   pkt_done (pulse after tail), pkt_count, busy.
// Flit layout: {type[1:0], dest, ts, payload}; all outputs registered.
module noc_traffic_gen #(
    parameter int          FLIT_W    = 64,
    parameter int          DEST_W    = 8,
    parameter int          TS_W      = 22,
    parameter int          NUM_DEST  = 16,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [7:0]        pkt_len,
    input  logic [1:0]        dest_mode,
    input  logic [DEST_W-1:0] fixed_dest,
    input  logic [7:0]        inj_gap,
    noc_traffic_gen_if.master tx,
    output logic              pkt_done,
    output logic [31:0]       pkt_count,
    output logic              busy
);
    localparam int PAY_W = FLIT_W - 2 - DEST_W - TS_W;
    localparam int SEL_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
    localparam logic [31:0] SEED = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_BODY,
        S_GAP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [TS_W-1:0]   ts_cnt;
    logic [31:0]       lfsr;
    logic [31:0]       lfsr_nx;
    logic [SEL_W-1:0]  rr_ptr;
    logic [7:0]        len_q;
    logic [7:0]        idx;
    logic [7:0]        gap_cnt;
    logic [DEST_W-1:0] pkt_dest;
    logic [TS_W-1:0]   pkt_ts;
    logic [DEST_W-1:0] new_dest;
    logic [7:0]        len_in;
    logic              xfer;
    logic              last;
    logic              load_head;
    logic              load_next;
    logic              tail_xfer;

    assign xfer   = tx.flit_valid && tx.flit_ready;
    assign len_in = (pkt_len == 8'd0) ? 8'd1 : pkt_len;
    assign last   = (idx == len_q - 8'd1);

    // The LFSR only moves on a transfer; the next flit's payload is taken
    // from the post-transfer value so it matches LFSR while presented.
    assign lfsr_nx = xfer ? {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]}
                          : lfsr;

    always_comb begin
        new_dest = fixed_dest;
        case (dest_mode)
            2'd1:    new_dest = (NUM_DEST > 1) ? DEST_W'(rr_ptr) : '0;
            2'd2:    new_dest = (NUM_DEST > 1) ? DEST_W'(lfsr_nx[SEL_W-1:0]) : '0;
            default: new_dest = fixed_dest;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        load_head = 1'b0;
        load_next = 1'b0;
        tail_xfer = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nx  = S_HEAD;
                    load_head = 1'b1;
                end
            end
            S_HEAD, S_BODY: begin
                if (xfer) begin
                    if (last) begin
                        tail_xfer = 1'b1;
                        if (inj_gap != 8'd0) begin
                            state_nx = S_GAP;
                        end else if (enable) begin
                            state_nx  = S_HEAD;
                            load_head = 1'b1;
                        end else begin
                            state_nx = S_IDLE;
                        end
                    end else begin
                        state_nx  = S_BODY;
                        load_next = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == 8'd0) begin
                    if (enable) begin
                        state_nx  = S_HEAD;
                        load_head = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt        <= '0;
            lfsr          <= SEED;
            rr_ptr        <= '0;
            len_q         <= 8'd1;
            idx           <= 8'd0;
            gap_cnt       <= 8'd0;
            pkt_dest      <= '0;
            pkt_ts        <= '0;
            tx.flit_out   <= '0;
            tx.flit_valid <= 1'b0;
            pkt_done      <= 1'b0;
            pkt_count     <= 32'd0;
            busy          <= 1'b0;
        end else begin
            ts_cnt        <= ts_cnt + TS_W'(1);
            lfsr          <= lfsr_nx;
            pkt_done      <= tail_xfer;
            busy          <= (state_nx != S_IDLE);
            tx.flit_valid <= (state_nx == S_HEAD) || (state_nx == S_BODY);
            if (tail_xfer) begin
                pkt_count <= pkt_count + 32'd1;
                gap_cnt   <= inj_gap - 8'd1;
            end else if (state == S_GAP && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
            if (load_head) begin
                len_q    <= len_in;
                idx      <= 8'd0;
                pkt_dest <= new_dest;
                pkt_ts   <= ts_cnt;
                if (dest_mode == 2'd1) begin
                    rr_ptr <= rr_ptr + SEL_W'(1);
                end
                tx.flit_out <= {(len_in == 8'd1) ? T_SINGLE : T_HEAD,
                                new_dest, ts_cnt, lfsr_nx[PAY_W-1:0]};
            end else if (load_next) begin
                idx         <= idx + 8'd1;
                tx.flit_out <= {(idx + 8'd1 == len_q - 8'd1) ? T_TAIL : T_BODY,
                                pkt_dest, pkt_ts, lfsr_nx[PAY_W-1:0]};
            end
        end
    end
endmodule

// File: tb/tb_noc_traffic_gen.sv
// tb_noc_traffic_gen: randomized and directed bench for noc_traffic_gen.
// A negedge monitor predicts every flit, done pulse and packet count.
module tb_noc_traffic_gen;
    localparam int          NUM_DEST = 4;
    localparam logic [31:0] SEED     = 32'h0000_0001;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] pkt_len;
    logic [1:0] dest_mode;
    logic [7:0] fixed_dest;
    logic [7:0] inj_gap;
    logic       pkt_done;
    logic [31:0] pkt_count;
    logic       busy;

    noc_traffic_gen_if #(.FLIT_W(64)) tx ();

    noc_traffic_gen #(
        .FLIT_W(64),
        .DEST_W(8),
        .TS_W(22),
        .NUM_DEST(NUM_DEST),
        .LFSR_SEED(SEED)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .pkt_len(pkt_len),
        .dest_mode(dest_mode),
        .fixed_dest(fixed_dest),
        .inj_gap(inj_gap),
        .tx(tx),
        .pkt_done(pkt_done),
        .pkt_count(pkt_count),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // Free-running cycle count, the reference for timestamps.
    int cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Reference model state.
    logic [31:0] m_lfsr = SEED;
    int          m_count = 0;
    int          rr_m = 0;
    bit          in_pkt = 0;
    int          flit_no = 0;
    int          exp_len = 1;
    logic [7:0]  m_dest = '0;
    logic [21:0] m_ts = '0;
    logic [1:0]  m_typ = '0;
    bit          exp_done = 0;
    bit          after_tail = 0;
    int          gap_seen = 0;
    bit          chk_gap = 0;
    bit          prev_valid = 0;
    bit          prev_ready = 0;
    logic [63:0] prev_flit = '0;
    logic [7:0]  dut_dest_q[$];

    always @(negedge clk) begin
        if (reset) begin
            m_lfsr     = SEED;
            m_count    = 0;
            rr_m       = 0;
            in_pkt     = 0;
            flit_no    = 0;
            exp_done   = 0;
            after_tail = 0;
            gap_seen   = 0;
            prev_valid = 0;
            prev_ready = 0;
            prev_flit  = '0;
            dut_dest_q.delete();
        end else begin
            if (!chk_gap) after_tail = 0;
            check("pkt_done", pkt_done, exp_done);
            if (exp_done) m_count++;
            exp_done = 0;
            check("pkt_count", pkt_count, m_count);
            if (prev_valid && !prev_ready) begin
                check("hold_valid", tx.flit_valid, 1);
                check("hold_flit", tx.flit_out, prev_flit);
            end else if (in_pkt) begin
                check("next_valid", tx.flit_valid, 1);
                flit_no++;
                m_typ = (flit_no == exp_len - 1) ? 2'b10 : 2'b00;
                check("body_flit", tx.flit_out, {m_typ, m_dest, m_ts, m_lfsr});
            end else if (tx.flit_valid) begin
                exp_len = (pkt_len == 8'd0) ? 1 : int'(pkt_len);
                m_ts    = 22'(cyc - 1);
                case (dest_mode)
                    2'd1: begin
                        m_dest = 8'(rr_m);
                        rr_m   = (rr_m + 1) % NUM_DEST;
                    end
                    2'd2:    m_dest = 8'(m_lfsr % NUM_DEST);
                    default: m_dest = fixed_dest;
                endcase
                if (after_tail) check("gap_len", gap_seen, inj_gap);
                after_tail = 0;
                in_pkt  = 1;
                flit_no = 0;
                m_typ = (exp_len == 1) ? 2'b11 : 2'b01;
                dut_dest_q.push_back(tx.flit_out[61:54]);
                check("head_flit", tx.flit_out, {m_typ, m_dest, m_ts, m_lfsr});
            end else if (after_tail) begin
                gap_seen++;
                check("gap_busy", busy, 1);
            end
            if (tx.flit_valid) check("busy", busy, 1);
            if (tx.flit_valid && tx.flit_ready) begin
                m_lfsr = lfsr_step(m_lfsr);
                if (in_pkt && flit_no == exp_len - 1) begin
                    in_pkt     = 0;
                    exp_done   = 1;
                    after_tail = 1;
                    gap_seen   = 0;
                end
            end
            prev_valid = tx.flit_valid;
            prev_ready = tx.flit_ready;
            prev_flit  = tx.flit_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!pkt_done && n < budget) begin
            tick();
            n++;
        end
        check("done_wait", pkt_done, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_wait", busy, 0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        reset         = 1'b1;
        enable        = 1'b0;
        pkt_len       = 8'd1;
        dest_mode     = 2'd0;
        fixed_dest    = 8'h00;
        inj_gap       = 8'd0;
        tx.flit_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", tx.flit_valid, 0);
        check("rst_flit", tx.flit_out, 64'h0);
        check("rst_done", pkt_done, 0);
        check("rst_count", pkt_count, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // 11-flit packet, enable dropped during the body.
        pkt_len    = 8'd11;
        fixed_dest = 8'h01;
        tick();
        enable = 1'b1;
        tick();
        check("head_lat", tx.flit_valid, 1);
        check("head_type", tx.flit_out[63:62], 2'b01);
        tick();
        enable     = 1'b0;
        pkt_len    = 8'd3;
        fixed_dest = 8'hAA;
        wait_done(40);
        check("t1_busy", busy, 0);
        check("t1_valid", tx.flit_valid, 0);
        check("t1_count", pkt_count, 1);
        repeat (3) tick();
        check("t1_stay", tx.flit_valid, 0);

        // Single-flit packets: lengths 1 and 0.
        for (int i = 0; i < 2; i++) begin
            pkt_len    = (i == 0) ? 8'd1 : 8'd0;
            fixed_dest = 8'h5A;
            tick();
            enable = 1'b1;
            tick();
            check("single_type", tx.flit_out[63:62], 2'b11);
            enable = 1'b0;
            wait_done(10);
            check("single_count", pkt_count, 2 + i);
            check("single_busy", busy, 0);
        end

        // Backpressure on body flit 2.
        pkt_len = 8'd5;
        tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick();
        check("bp_type", tx.flit_out[63:62], 2'b00);
        tx.flit_ready = 1'b0;
        repeat (3) tick();
        check("bp_valid", tx.flit_valid, 1);
        tx.flit_ready = 1'b1;
        wait_done(20);
        check("bp_count", pkt_count, 4);

        // Round-robin destinations, back-to-back packets.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        dest_mode = 2'd1;
        pkt_len   = 8'd2;
        inj_gap   = 8'd0;
        chk_gap   = 1'b1;
        enable    = 1'b1;
        n = 0;
        while (pkt_count < 6 && n < 200) begin
            tick();
            n++;
        end
        check("rr_run", pkt_count >= 6, 1);
        enable  = 1'b0;
        chk_gap = 1'b0;
        wait_idle(50);
        check("rr_heads", dut_dest_q.size() >= 6, 1);
        if (dut_dest_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check("rr_dest", dut_dest_q[i], i % 4);
            end
        end

        // Fixed injection gap of 3 cycles.
        dest_mode  = 2'd0;
        fixed_dest = 8'h33;
        pkt_len    = 8'd2;
        inj_gap    = 8'd3;
        chk_gap    = 1'b1;
        enable     = 1'b1;
        base = int'(pkt_count);
        n = 0;
        while (int'(pkt_count) < base + 4 && n < 200) begin
            tick();
            n++;
        end
        check("gap_run", int'(pkt_count) >= base + 4, 1);
        enable  = 1'b0;
        chk_gap = 1'b0;
        wait_idle(50);

        // Reset during the body of a 5-flit packet.
        inj_gap    = 8'd0;
        pkt_len    = 8'd5;
        fixed_dest = 8'h0F;
        tick();
        enable = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", tx.flit_valid, 0);
        check("mid_rst_count", pkt_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", pkt_done, 0);
        tick();
        check("post_rst_valid", tx.flit_valid, 1);
        check("post_rst_type", tx.flit_out[63:62], 2'b01);
        check("post_rst_pay", tx.flit_out[31:0], SEED);
        enable = 1'b0;
        wait_done(20);
        check("post_rst_count", pkt_count, 1);

        // Longest packet.
        dest_mode  = 2'd3;
        fixed_dest = 8'h77;
        pkt_len    = 8'd255;
        tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_done(300);
        check("len255_count", pkt_count, 2);
        wait_idle(10);

        // Randomized segments.
        for (int s = 0; s < 12; s++) begin
            pkt_len    = 8'($urandom_range(0, 12));
            dest_mode  = 2'($urandom_range(0, 3));
            fixed_dest = 8'($urandom);
            inj_gap    = 8'($urandom_range(0, 4));
            chk_gap    = 1'b1;
            enable     = 1'b1;
            for (int c = 0; c < 80; c++) begin
                tx.flit_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            enable        = 1'b0;
            chk_gap       = 1'b0;
            tx.flit_ready = 1'b1;
            wait_idle(300);
        end
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/noc_traffic_gen.md
# noc_traffic_gen

Parametrised synthetic-traffic source for NoC time-calculation experiments. Emits complete wormhole packets (head, body, tail) with a valid/ready handshake, configurable packet length, destination-selection mode and inter-packet injection gap. Each flit carries a latency timestamp and an LFSR payload. Sits at a router's local injection port; the packet counter feeds the latency/throughput statistics logic.

## Interface
- FLIT_W, 64, flit width; layout {type[1:0], dest[DEST_W-1:0], ts[TS_W-1:0], payload[PAY_W-1:0]}, PAY_W = FLIT_W-2-DEST_W-TS_W, legal range 1..32
- DEST_W, 8, destination address field width
- TS_W, 22, timestamp field width
- NUM_DEST, 16, number of destinations; power of two, ≤ 2^DEST_W
- LFSR_SEED, 32'h0000_0001, LFSR reset value; 0 is replaced by 1

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  permit new packets; a packet in flight always completes
- pkt_len  in  8  flits per packet; 0 is treated as 1
- dest_mode  in  2  0 = fixed, 1 = round-robin, 2 = random, 3 = fixed
- fixed_dest  in  DEST_W  destination for modes 0 and 3
- inj_gap  in  8  idle cycles inserted after each tail
- flit_out  out  FLIT_W  flit data
- flit_valid  out  1  flit_out is valid
- flit_ready  in  1  downstream accepts; transfer = flit_valid & flit_ready
- pkt_done  out  1  one-cycle pulse on the cycle after the tail transfer
- pkt_count  out  32  packets completed, wraps
- busy  out  1  high in HEAD, BODY or GAP

## Operation
- Flit type codes: 01 head, 00 body, 10 tail, 11 single-flit packet (pkt_len ≤ 1).
- States:
  - IDLE: enable=1 → HEAD.
  - HEAD: on transfer, if len=1 → tail handling; else → BODY.
  - BODY: remaining flits; the last one is typed tail.
  - GAP: count down inj_gap cycles, then → HEAD if enable, else IDLE.
- Tail handling: if inj_gap=0 and enable=1 → HEAD; if inj_gap=0 and enable=0 → IDLE; otherwise → GAP.
- On entry to HEAD, latch pkt_len, destination and timestamp into per-packet registers. Input changes mid-packet are ignored.
- Timestamp: free-running TS_W-bit cycle counter, reset to 0, wraps modulo 2^TS_W. The counter value on the cycle HEAD is entered is copied into every flit of that packet.
- Destination:
  - Fixed: fixed_dest.
  - Round-robin: pointer starts at 0, increments by 1 per packet, wraps at NUM_DEST-1.
  - Random: LFSR[log2(NUM_DEST)-1:0] at HEAD entry, zero-extended.
  - Upper DEST_W bits above log2(NUM_DEST) are 0 in both non-fixed modes.
- LFSR: 32-bit Fibonacci, shift left, feedback = l[31]^l[21]^l[1]^l[0]. Advances once per flit transfer only. Payload = LFSR[PAY_W-1:0] at the time the flit is presented.
- Flit counter: 8 bits. Tail is flit number len-1. pkt_len=255 is legal.

## Timing
- All outputs are registered.
- Reset values: flit_valid=0, flit_out=0, pkt_done=0, pkt_count=0, busy=0. Internal: timestamp=0, round-robin pointer=0, LFSR=seed, state=IDLE.
- enable rises in cycle N → flit_valid=1 and head on flit_out in N+1.
- flit_out and flit_valid hold stable while flit_valid=1 and flit_ready=0 (AXI-style).
- The next flit appears the cycle after a transfer. At flit_ready=1 throughput is 1 flit/cycle.
- Back-to-back packets (inj_gap=0, enable=1): next head in the cycle after tail transfer. No bubble.
- inj_gap=G>0: flit_valid low for exactly G cycles between tail transfer and next head.
- pkt_done and the pkt_count increment occur in the same cycle, one cycle after tail transfer.
- enable dropped mid-packet: remaining flits are still sent, then IDLE (or GAP, then IDLE).
- reset mid-packet: the packet is abandoned and all reset values apply in the next cycle. No partial tail is emitted.
- Timestamp wrap: 2^TS_W-1 → 0 with no other effect.

## Test plan
- Reset, then enable=1, pkt_len=11, mode 0, fixed_dest=8'h01, inj_gap=0, ready=1 → types 01, nine 00, 10 on consecutive cycles; all dest=01; identical ts; pkt_done once; pkt_count=1.
- pkt_len=1 → single flit type 11. pkt_len=0 → identical behaviour.
- Backpressure: ready low for 3 cycles during body flit 2 → flit_out stable for those cycles; LFSR payload does not advance; no flits lost or duplicated.
- Mode 1, NUM_DEST=4, pkt_len=2, 6 packets → destinations 0,1,2,3,0,1. Mode 2 → dest equals LFSR[1:0] at head entry per reference model.
- inj_gap=3 → exactly 3 flit_valid=0 cycles between tail and next head. inj_gap=0 → zero-cycle gap. Deassert enable during body → packet completes, then IDLE, busy=0.
- Assert reset during the body of a 5-flit packet → next cycle flit_valid=0 and pkt_count=0. After release, the first head carries payload from LFSR_SEED.
